// File: rtl/mmu_utlb_if.sv
// Request/response and main-TLB lookup bundle for the micro-TLB.
// tlb_resp is the combinational result of the main TLB for tlb_vaddr/tlb_asid.
interface mmu_utlb_if;
  typedef logic [31:0] virt_t;
  typedef logic [31:0] phys_t;
  typedef struct packed {
    logic       miss;
    logic       valid;
    logic       dirty;
    logic       g;
    logic [2:0] cache_flag;
    phys_t      paddr;
  } tlb_resp_t;

  logic      req_valid;
  logic      req_ready;
  virt_t     req_vaddr;
  logic [7:0] req_asid;
  logic      req_store;
  logic      resp_valid;
  phys_t     resp_paddr;
  logic      resp_uncached;
  logic      resp_refill;
  logic      resp_invalid;
  logic      resp_modified;
  virt_t     tlb_vaddr;
  logic [7:0] tlb_asid;
  tlb_resp_t tlb_resp;
  logic      flush;

  modport slave (
    input  req_valid, req_vaddr, req_asid, req_store, tlb_resp, flush,
    output req_ready, resp_valid, resp_paddr, resp_uncached, resp_refill,
           resp_invalid, resp_modified, tlb_vaddr, tlb_asid
  );
  modport master (
    output req_valid, req_vaddr, req_asid, req_store, tlb_resp, flush,
    input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_refill,
           resp_invalid, resp_modified, tlb_vaddr, tlb_asid
  );
endinterface

// File: rtl/mmu_utlb.sv
// Fully associative micro-TLB in front of a combinational main TLB, round-robin fill.
// Define UTLB_STATS_EN to build the hit/miss counters; otherwise they read 0.
module mmu_utlb #(
  parameter int N_UTLB_ENTRIES = 4,
  parameter int N_TLB_ENTRIES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  mmu_utlb_if.slave   bus,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
);
  localparam int PW = $clog2(N_UTLB_ENTRIES);

  if (N_UTLB_ENTRIES < 2 || N_UTLB_ENTRIES > 16 ||
      (N_UTLB_ENTRIES & (N_UTLB_ENTRIES - 1)) != 0 || N_TLB_ENTRIES < 1) begin : g_bad_cfg
    $error("mmu_utlb: unsupported entry counts");
  end

  typedef enum logic {IDLE, LOOKUP} state_t;
  state_t state_q, state_d;

  logic [N_UTLB_ENTRIES-1:0]       tag_valid;
  logic [N_UTLB_ENTRIES-1:0][19:0] e_vpn, e_pfn;
  logic [N_UTLB_ENTRIES-1:0][7:0]  e_asid;
  logic [N_UTLB_ENTRIES-1:0][2:0]  e_c;
  logic [N_UTLB_ENTRIES-1:0]       e_g, e_d;
  logic [PW-1:0]                   rr;
  logic                            store_q;

  logic                      accept, bypass, hit, fill_ok;
  logic [N_UTLB_ENTRIES-1:0] hit_vec;
  logic [PW-1:0]             hit_idx;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bypass        = bus.req_vaddr[31:30] == 2'b10;
  // A flush in the same cycle wins over any match, so the request takes the miss path.
  for (genvar i = 0; i < N_UTLB_ENTRIES; i++) begin : g_cmp
    assign hit_vec[i] = tag_valid[i] && !bus.flush &&
                        (e_vpn[i] == bus.req_vaddr[31:12]) &&
                        (e_g[i] || (e_asid[i] == bus.req_asid));
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_UTLB_ENTRIES; i++) begin
      if (hit_vec[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign fill_ok = !bus.tlb_resp.miss && bus.tlb_resp.valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bypass && !hit) state_d = LOOKUP;
      LOOKUP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid         <= '0;
      rr                <= '0;
      store_q           <= 1'b0;
      bus.resp_valid    <= 1'b0;
      bus.resp_paddr    <= '0;
      bus.resp_uncached <= 1'b0;
      bus.resp_refill   <= 1'b0;
      bus.resp_invalid  <= 1'b0;
      bus.resp_modified <= 1'b0;
      bus.tlb_vaddr     <= '0;
      bus.tlb_asid      <= '0;
    end else begin
      bus.resp_valid    <= 1'b0;
      bus.resp_refill   <= 1'b0;
      bus.resp_invalid  <= 1'b0;
      bus.resp_modified <= 1'b0;
      if (state_q == IDLE) begin
        if (accept && bypass) begin
          bus.resp_valid    <= 1'b1;
          bus.resp_paddr    <= bus.req_vaddr & 32'h1FFF_FFFF;
          bus.resp_uncached <= bus.req_vaddr[29];
        end else if (accept && hit) begin
          bus.resp_valid    <= 1'b1;
          bus.resp_paddr    <= {e_pfn[hit_idx], bus.req_vaddr[11:0]};
          bus.resp_uncached <= e_c[hit_idx] == 3'd2;
          bus.resp_modified <= bus.req_store && !e_d[hit_idx];
        end else if (accept) begin
          bus.tlb_vaddr <= bus.req_vaddr;
          bus.tlb_asid  <= bus.req_asid;
          store_q       <= bus.req_store;
        end
      end else begin
        bus.resp_valid    <= 1'b1;
        bus.resp_paddr    <= bus.tlb_resp.paddr;
        bus.resp_uncached <= bus.tlb_resp.cache_flag == 3'd2;
        bus.resp_refill   <= bus.tlb_resp.miss;
        bus.resp_invalid  <= !bus.tlb_resp.miss && !bus.tlb_resp.valid;
        bus.resp_modified <= !bus.tlb_resp.miss && bus.tlb_resp.valid &&
                             store_q && !bus.tlb_resp.dirty;
        if (fill_ok) begin
          tag_valid[rr] <= 1'b1;
          e_vpn[rr]     <= bus.tlb_vaddr[31:12];
          e_asid[rr]    <= bus.tlb_asid;
          e_g[rr]       <= bus.tlb_resp.g;
          e_pfn[rr]     <= bus.tlb_resp.paddr[31:12];
          e_c[rr]       <= bus.tlb_resp.cache_flag;
          e_d[rr]       <= bus.tlb_resp.dirty;
          rr            <= rr + 1'b1;
        end
      end
      if (bus.flush) tag_valid <= '0;
    end
  end

`ifdef UTLB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (accept && !bypass) begin
      if (hit) stat_hits   <= stat_hits + 32'd1;
      else     stat_misses <= stat_misses + 32'd1;
    end
  end
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_mmu_utlb.sv
// Randomized scoreboard bench for mmu_utlb against a FIFO-replacement reference model.
module tb_mmu_utlb;
  localparam int NU = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stat_hits, stat_misses;
  int          cyc = 0;
  int          tests = 0, fails = 0;

  mmu_utlb_if bus();

  mmu_utlb #(.N_UTLB_ENTRIES(NU), .N_TLB_ENTRIES(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main TLB contents
  typedef struct {
    bit [19:0] vpn; bit [19:0] pfn; bit [7:0] asid;
    bit g; bit v; bit d; bit [2:0] c;
  } pte_t;
  pte_t pt[9];

  function automatic void pt_lookup(input bit [19:0] vpn, input bit [7:0] asid,
                                    output bit found, output pte_t e);
    found = 0;
    e = '{default: 0};
    for (int i = 0; i < 9; i++)
      if (!found && pt[i].vpn == vpn && (pt[i].g || pt[i].asid == asid)) begin
        found = 1; e = pt[i];
      end
  endfunction

  always_comb begin
    bit   f;
    pte_t e;
    bus.tlb_resp = '0;
    pt_lookup(bus.tlb_vaddr[31:12], bus.tlb_asid, f, e);
    if (!f) bus.tlb_resp.miss = 1'b1;
    else begin
      bus.tlb_resp.valid      = e.v;
      bus.tlb_resp.dirty      = e.d;
      bus.tlb_resp.g          = e.g;
      bus.tlb_resp.cache_flag = e.c;
      bus.tlb_resp.paddr      = {e.pfn, bus.tlb_vaddr[11:0]};
    end
  end

  // Reference micro-TLB: a FIFO of NU slots, oldest fill evicted first
  typedef struct {
    bit vld; bit [19:0] vpn; bit [19:0] pfn; bit [7:0] asid; bit g; bit d; bit [2:0] c;
  } uent_t;
  uent_t       uq[$];
  int          m_hits, m_misses;
  bit [31:0]   m_tlb_vaddr;

  typedef struct {
    bit [31:0] paddr; bit unc; bit refill; bit inv; bit mod; int lat; int acc;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_reset();
    uent_t z;
    z = '{default: 0};
    uq.delete();
    for (int i = 0; i < NU; i++) uq.push_back(z);
    m_hits = 0; m_misses = 0; m_tlb_vaddr = 0;
  endfunction

  function automatic void model_flush();
    foreach (uq[i]) uq[i].vld = 0;
  endfunction

  function automatic int model_hit(input bit [31:0] va, input bit [7:0] asid);
    foreach (uq[i])
      if (uq[i].vld && uq[i].vpn == va[31:12] && (uq[i].g || uq[i].asid == asid)) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input bit [31:0] va, input bit [7:0] asid, input bit st,
                        input bit fl_same, input bit fl_look);
    exp_t  x;
    bit    miss_path, found;
    pte_t  p;
    int    idx, w;
    uent_t ne;
    @(negedge clk);
    bus.req_valid = 1; bus.req_vaddr = va; bus.req_asid = asid; bus.req_store = st;
    bus.flush = fl_same;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 0; bus.flush = 0;
      return;
    end
    x = '{default: 0};
    x.acc = cyc;
    miss_path = 0; found = 0; p = '{default: 0};
    if (va[31:30] == 2'b10) begin
      x.paddr = va & 32'h1FFF_FFFF; x.unc = va[29]; x.lat = 1;
    end else begin
      idx = fl_same ? -1 : model_hit(va, asid);
      if (idx >= 0) begin
        x.paddr = {uq[idx].pfn, va[11:0]}; x.unc = (uq[idx].c == 3'd2);
        x.mod = st && !uq[idx].d; x.lat = 1; m_hits++;
      end else begin
        miss_path = 1; m_misses++; m_tlb_vaddr = va; x.lat = 2;
        pt_lookup(va[31:12], asid, found, p);
        if (!found) x.refill = 1;
        else begin
          x.paddr = {p.pfn, va[11:0]}; x.unc = (p.c == 3'd2);
          x.inv = !p.v; x.mod = p.v && st && !p.d;
        end
      end
    end
    sbq.push_back(x);
    @(posedge clk);
    if (fl_same) model_flush();
    @(negedge clk);
    bus.req_valid = 0; bus.flush = 0;
    if (miss_path) begin
      bus.flush = fl_look;
      @(posedge clk);
      if (fl_look) model_flush();
      else if (found && p.v) begin
        ne = '{vld: 1, vpn: va[31:12], pfn: p.pfn, asid: asid, g: p.g, d: p.d, c: p.c};
        uq.push_back(ne);
        void'(uq.pop_front());
      end
      @(negedge clk);
      bus.flush = 0;
    end
    chk("tlb_vaddr_hold", bus.tlb_vaddr, m_tlb_vaddr);
  endtask

  task automatic do_flush();
    @(negedge clk); bus.flush = 1;
    @(posedge clk); model_flush();
    @(negedge clk); bus.flush = 0;
  endtask

  // Monitor: pops the scoreboard on every response
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (bus.resp_valid) begin
        if (sbq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("resp_paddr",    bus.resp_paddr, e.paddr);
          chk("resp_uncached", 32'(bus.resp_uncached), 32'(e.unc));
          chk("resp_refill",   32'(bus.resp_refill), 32'(e.refill));
          chk("resp_invalid",  32'(bus.resp_invalid), 32'(e.inv));
          chk("resp_modified", 32'(bus.resp_modified), 32'(e.mod));
          chk("resp_latency",  32'(cyc - e.acc), 32'(e.lat));
        end
      end else begin
        chk("idle_flags", {29'd0, bus.resp_refill, bus.resp_invalid, bus.resp_modified}, 32'd0);
      end
    end
  end

  initial begin
    bit [31:0] va;
    int        k;
    pt[0] = '{vpn: 20'h00400, pfn: 20'h1F000, asid: 0, g: 1, v: 1, d: 1, c: 3'd3};
    pt[1] = '{vpn: 20'h00401, pfn: 20'h12345, asid: 0, g: 1, v: 1, d: 0, c: 3'd2};
    pt[2] = '{vpn: 20'h00402, pfn: 20'h00222, asid: 0, g: 1, v: 0, d: 1, c: 3'd3};
    pt[3] = '{vpn: 20'h00403, pfn: 20'h00777, asid: 5, g: 0, v: 1, d: 1, c: 3'd3};
    for (int i = 0; i < 5; i++)
      pt[4+i] = '{vpn: 20'h00410 + 20'(i), pfn: 20'h30000 + 20'(i), asid: 0,
                  g: 1, v: 1, d: i[0], c: 3'(i)};
    rst = 1; bus.req_valid = 0; bus.req_vaddr = 0; bus.req_asid = 0;
    bus.req_store = 0; bus.flush = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_paddr", bus.resp_paddr, 32'd0);
    chk("rst_tlb_vaddr",  bus.tlb_vaddr, 32'd0);
    chk("rst_tlb_asid",   32'(bus.tlb_asid), 32'd0);
    chk("rst_stat_hits",  stat_hits, 32'd0);
    chk("rst_stat_misses", stat_misses, 32'd0);
    rst = 0;
    #1 chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    model_reset();

    // bypass
    do_req(32'hA000_1234, 8'd1, 0, 0, 0);
    do_req(32'h8000_0040, 8'd1, 1, 0, 0);
    // miss then hit
    do_req(32'h0040_0010, 8'd1, 0, 0, 0);
    do_req(32'h0040_0010, 8'd1, 0, 0, 0);
    // refill twice, invalid twice
    do_req(32'h0050_0000, 8'd1, 0, 0, 0);
    do_req(32'h0050_0000, 8'd1, 0, 0, 0);
    do_req(32'h0040_2000, 8'd1, 0, 0, 0);
    do_req(32'h0040_2000, 8'd1, 0, 0, 0);
    // modified on miss and hit paths
    do_req(32'h0040_1004, 8'd1, 1, 0, 0);
    do_req(32'h0040_1008, 8'd1, 1, 0, 0);
    do_req(32'h0040_100C, 8'd1, 0, 0, 0);
    // ASID / flush
    do_req(32'h0040_3008, 8'd5, 0, 0, 0);
    do_req(32'h0040_3008, 8'd6, 0, 0, 0);
    do_req(32'h0040_3008, 8'd5, 0, 0, 0);
    do_flush();
    do_req(32'h0040_3008, 8'd5, 0, 0, 0);
    do_req(32'h0040_0010, 8'd1, 0, 0, 1);
    do_req(32'h0040_0010, 8'd1, 0, 0, 0);
    do_req(32'h0040_0010, 8'd1, 0, 1, 0);
    do_req(32'h0040_0010, 8'd1, 0, 0, 0);
    // wrap: NU+1 fills evict the first page
    do_flush();
    for (int i = 0; i < NU + 1; i++) do_req({20'h00410 + 20'(i), 12'h010}, 8'd1, 0, 0, 0);
    for (int i = 1; i < NU + 1; i++) do_req({20'h00410 + 20'(i), 12'h020}, 8'd1, 0, 0, 0);
    do_req(32'h0041_0030, 8'd1, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 11);
      if (k < 9)       va = {pt[k].vpn, 12'($urandom)};
      else if (k == 9) va = {20'h00500 + 20'($urandom_range(0, 3)), 12'($urandom)};
      else if (k == 10) va = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
      else             va = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
      do_req(va, 8'($urandom_range(5, 6)), 1'($urandom),
             $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // reset during LOOKUP aborts the miss
    do_flush();
    @(negedge clk);
    bus.req_valid = 1; bus.req_vaddr = 32'h0040_0010; bus.req_asid = 1; bus.req_store = 0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    chk("abort_stat_hits", stat_hits, 32'd0);
    do_req(32'h0040_0010, 8'd1, 0, 0, 0);
    do_req(32'h0040_0010, 8'd1, 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
`ifdef UTLB_STATS_EN
    chk("stat_hits",   stat_hits,   32'(m_hits));
    chk("stat_misses", stat_misses, 32'(m_misses));
`else
    chk("stat_hits_off",   stat_hits,   32'd0);
    chk("stat_misses_off", stat_misses, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
